hilo_reg: RTL
=============

HILO_REG -- requirements
Module: hilo_reg

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, HI/LO data width.
REQ-002 SHALL provide parameter DEPTH, default 2, pending-write buffer entries; legal values are 2 and 4.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_valid  input  1  producer (mult/div result) offers a HI/LO write.
REQ-006 SHALL have port wr_ready  output  1  buffer can accept the offered write this cycle.
REQ-007 SHALL have ports we_hi, we_lo  input  1 each  per-half write enables of the offered write.
REQ-008 SHALL have ports hi_wdata, lo_wdata  input  DATA_W each  offered HI/LO values.
REQ-009 SHALL have port commit  input  1  retire the oldest pending entry (write-back stage).
REQ-010 SHALL have port flush  input  1  discard all uncommitted entries.
REQ-011 SHALL have ports hi_rdata, lo_rdata  output  DATA_W each  HI/LO values for mfhi/mflo.
REQ-012 SHALL have port pending_cnt  output  3  number of occupied entries.
REQ-013 SHALL have port rd_stall  output  1  read result not yet valid (see Configuration).

Function
REQ-014 SHALL hold architectural registers arch_hi and arch_lo plus a FIFO of DEPTH entries {we_hi, we_lo, hi, lo}.
REQ-015 SHALL accept a write at a rising edge when wr_valid and wr_ready are both 1; wr_ready SHALL be 1 when pending_cnt < DEPTH, or when pending_cnt == DEPTH and commit is 1 in the same cycle.
REQ-016 SHALL accept and buffer entries with we_hi = we_lo = 0; such an entry retires without changing arch_hi or arch_lo.
REQ-017 SHALL, on commit with pending_cnt > 0, write the oldest entry's hi to arch_hi if its we_hi is 1, and its lo to arch_lo if its we_lo is 1, then free that entry.
REQ-018 SHALL ignore commit when pending_cnt == 0.
REQ-019 SHALL, on flush, still perform any same-cycle commit of the oldest entry, then discard all remaining entries and any same-cycle offered write; pending_cnt SHALL be 0 after that edge.
REQ-020 SHALL perform a same-cycle accepted write and commit without a flush together, leaving pending_cnt unchanged.
REQ-021 SHALL wrap the read and write pointers modulo DEPTH.
REQ-022 SHALL drive hi_rdata and lo_rdata combinationally from registered state only, never from the same-cycle wr_* inputs.
REQ-023 SHALL make a write accepted at edge N readable from after edge N when forwarding is enabled, and from after its commit edge when forwarding is disabled.

Reset
REQ-024 SHALL, while rst is 0, clear arch_hi, arch_lo, pointers and pending_cnt to 0, asynchronously.
REQ-025 SHALL therefore drive hi_rdata = lo_rdata = 0, wr_ready = 1 and rd_stall = 0 during and immediately after reset.
REQ-026 SHALL, when reset is asserted mid-operation, lose all pending entries with no partial commit.

Configuration
REQ-027 SHALL compile the forwarding path in only when macro HILO_FWD_EN is defined.
REQ-028 With HILO_FWD_EN defined: hi_rdata SHALL be the hi of the youngest pending entry with we_hi = 1, else arch_hi; lo_rdata SHALL be resolved the same way using we_lo and arch_lo; rd_stall SHALL be tied to 0.
REQ-029 Without HILO_FWD_EN: hi_rdata SHALL equal arch_hi and lo_rdata SHALL equal arch_lo; rd_stall SHALL be 1 whenever any pending entry has we_hi or we_lo set.

Verification
REQ-030 Reset, then write {1,1,hi=0x12345678,lo=0x9ABCDEF0}: with forwarding, rdata = those values on the next cycle while arch is still 0; after commit, arch holds them.
REQ-031 Write A {we_hi=1,hi=0x11}, then write B {we_hi=1,hi=0x22} without commit: hi_rdata = 0x22 and wr_ready = 0 at DEPTH 2; commit A plus offer C in the same cycle is accepted and pending_cnt stays 2.
REQ-032 Write {we_lo=1,lo=0x5}, then write {we_hi=1,hi=0x7}: lo_rdata = 0x5 and hi_rdata = 0x7 (per-half youngest match).
REQ-033 Two entries pending, then commit + flush + wr_valid in the same cycle: oldest entry retires to arch, pending_cnt = 0 next cycle, and the offered write is dropped.
REQ-034 Without HILO_FWD_EN, one entry pending: rd_stall = 1 and rdata = old arch value; after commit, rd_stall = 0 and rdata = new value.
REQ-035 Assert rst with 2 entries pending: all outputs return to their reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/hilo_reg.sv
// ---------------------------------------------------------------------------
// hilo_reg -- HI/LO register pair with a small in-order pending-write buffer.
//
// Multiply/divide results are offered as HI/LO writes with per-half enables.
// Each accepted write is held in a FIFO until the write-back stage commits
// it. Only then does it update the architectural arch_hi / arch_lo. A flush
// discards everything that has not been committed.
//
// Build option:
//   HILO_FWD_EN  when defined, reads of HI/LO come from the youngest pending
//                entry that writes that half, falling back to the
//                architectural value. rd_stall is tied low.
//                When undefined, reads return the architectural values only.
//                rd_stall is raised while any pending entry writes a half.
//
// Parameters:
//   DATA_W       HI/LO data width.
//   DEPTH        pending-write buffer entries. Only 2 and 4 are legal.
//
// Ports:
//   clk          sole clock, rising edge.
//   rst          asynchronous, active-low reset.
//   wr_valid     producer offers a HI/LO write.
//   wr_ready     buffer can take the offered write this cycle.
//   we_hi/we_lo  per-half write enables of the offered write.
//   hi_wdata     offered HI value.
//   lo_wdata     offered LO value.
//   commit       retire the oldest pending entry.
//   flush        discard all uncommitted entries and the offered write.
//   hi_rdata     HI value for mfhi.
//   lo_rdata     LO value for mflo.
//   pending_cnt  number of occupied buffer entries.
//   rd_stall     read data not yet valid. Used only without forwarding.
// ---------------------------------------------------------------------------
module hilo_reg #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              we_hi,
    input  logic              we_lo,
    input  logic [DATA_W-1:0] hi_wdata,
    input  logic [DATA_W-1:0] lo_wdata,
    input  logic              commit,
    input  logic              flush,
    output logic [DATA_W-1:0] hi_rdata,
    output logic [DATA_W-1:0] lo_rdata,
    output logic [2:0]        pending_cnt,
    output logic              rd_stall
);

    // DEPTH is restricted to powers of two (2 or 4). Because of that, the
    // pointers wrap modulo DEPTH simply by overflowing their natural width.
    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] arch_hi_q, arch_hi_d;
    logic [DATA_W-1:0] arch_lo_q, arch_lo_d;
    logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [2:0]        cnt_q,     cnt_d;

    // Entry payload. These registers have no reset. Whether an entry is
    // meaningful is decided entirely by the pointers and the count, and
    // those are reset.
    logic              ent_we_hi_q [DEPTH];
    logic              ent_we_lo_q [DEPTH];
    logic [DATA_W-1:0] ent_hi_q    [DEPTH];
    logic [DATA_W-1:0] ent_lo_q    [DEPTH];

    // -----------------------------------------------------------------------
    // Handshake and control decode
    // -----------------------------------------------------------------------
    logic do_commit;
    logic do_write;

    // A commit on an empty buffer is ignored.
    assign do_commit = commit && (cnt_q != 3'd0);

    // When the buffer is full, a same-cycle commit frees a slot, so the
    // offered write can still be taken. A full buffer is never empty, so
    // commit here implies do_commit.
    assign wr_ready  = (cnt_q < DEPTH_C) || ((cnt_q == DEPTH_C) && commit);

    // A flush drops the offered write even if it was handshaken.
    assign do_write  = wr_valid && wr_ready && !flush;

    // -----------------------------------------------------------------------
    // Slot occupancy: a slot is live when its distance from the read
    // pointer (its age, with 0 = oldest) is below the occupancy count.
    // -----------------------------------------------------------------------
    logic [DEPTH-1:0] slot_live;
    logic [DEPTH-1:0] slot_writes;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PTR_W-1:0] age;
            assign age             = PTR_W'(gi) - rd_ptr_q;
            assign slot_live[gi]   = {{(3-PTR_W){1'b0}}, age} < cnt_q;
            assign slot_writes[gi] = slot_live[gi]
                                     && (ent_we_hi_q[gi] || ent_we_lo_q[gi]);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        arch_hi_d = arch_hi_q;
        arch_lo_d = arch_lo_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;

        // Retire the oldest entry into the architectural registers. A
        // commit is still honoured in a flush cycle.
        if (do_commit) begin
            if (ent_we_hi_q[rd_ptr_q]) begin
                arch_hi_d = ent_hi_q[rd_ptr_q];
            end
            if (ent_we_lo_q[rd_ptr_q]) begin
                arch_lo_d = ent_lo_q[rd_ptr_q];
            end
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (flush) begin
            // Empty the buffer. Both pointers meet just past the entry that
            // was committed this cycle, if there was one.
            wr_ptr_d = rd_ptr_d;
            cnt_d    = 3'd0;
        end else begin
            if (do_write) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            // A simultaneous write and commit leaves the count unchanged.
            cnt_d = cnt_q + {2'b00, do_write} - {2'b00, do_commit};
        end
    end

    // -----------------------------------------------------------------------
    // Control / architectural registers (asynchronous reset)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arch_hi_q <= '0;
            arch_lo_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            arch_hi_q <= arch_hi_d;
            arch_lo_q <= arch_lo_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Entry payload registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (do_write) begin
            ent_we_hi_q[wr_ptr_q] <= we_hi;
            ent_we_lo_q[wr_ptr_q] <= we_lo;
            ent_hi_q[wr_ptr_q]    <= hi_wdata;
            ent_lo_q[wr_ptr_q]    <= lo_wdata;
        end
    end

    assign pending_cnt = cnt_q;

    // -----------------------------------------------------------------------
    // Read path. It uses registered state only, never same-cycle wr_* data.
    // -----------------------------------------------------------------------
`ifdef HILO_FWD_EN
    // Walk the live entries from oldest to youngest. Each half keeps the
    // last match it sees, so the youngest writer of that half wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hi_rdata = arch_hi_q;
        lo_rdata = arch_lo_q;
        idx      = rd_ptr_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if (slot_live[idx] && ent_we_hi_q[idx]) begin
                hi_rdata = ent_hi_q[idx];
            end
            if (slot_live[idx] && ent_we_lo_q[idx]) begin
                lo_rdata = ent_lo_q[idx];
            end
        end
    end

    // Forwarding always gives current data, so reads never stall.
    assign rd_stall = 1'b0;

    // The per-slot write summary is only needed when reads can stall.
    logic unused_slot_writes;
    assign unused_slot_writes = ^slot_writes;
`else
    assign hi_rdata = arch_hi_q;
    assign lo_rdata = arch_lo_q;

    // The architectural value is stale while any live entry will overwrite
    // either half.
    assign rd_stall = |slot_writes;
`endif

endmodule
